// File: rtl/core_wback_vl_if.sv
// Writeback-stage bundle: W-stage operands, load-response bus and register-file write port.
interface core_wback_vl_if #(
  parameter int XLEN       = 32,
  parameter int RESP_DEPTH = 2
);
  localparam int CW = $clog2(RESP_DEPTH) + 1;

  logic            w_valid;
  logic            w_ready;
  logic [4:0]      w_rd;
  logic            w_reg_wen;
  logic [2:0]      w_reg_wsel;
  logic [XLEN-1:0] w_alu_out;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_pc;
  logic [XLEN-1:0] w_pc4;
  logic [XLEN-1:0] w_csr_value;
  logic [1:0]      w_alu_sum_lo;
  logic [2:0]      w_mem_type;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_rerr;
  logic [CW-1:0]   mem_credit;
  logic            rf_wen;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            load_fault;
  logic            resp_overflow;

  modport slave (
    input  w_valid, w_rd, w_reg_wen, w_reg_wsel, w_alu_out, w_imm, w_pc, w_pc4,
           w_csr_value, w_alu_sum_lo, w_mem_type, mem_rvalid, mem_rdata, mem_rerr,
    output w_ready, mem_credit, rf_wen, rf_waddr, rf_wdata, load_fault, resp_overflow
  );

  modport master (
    output w_valid, w_rd, w_reg_wen, w_reg_wsel, w_alu_out, w_imm, w_pc, w_pc4,
           w_csr_value, w_alu_sum_lo, w_mem_type, mem_rvalid, mem_rdata, mem_rerr,
    input  w_ready, mem_credit, rf_wen, rf_waddr, rf_wdata, load_fault, resp_overflow
  );
endinterface

// File: rtl/core_wback_vl.sv
// Writeback stage for variable-latency loads: in-order response FIFO with same-cycle bypass,
// stalls W while a load waits, retires loads with a fault on bus error or timeout.
module core_wback_vl #(
  parameter int XLEN       = 32,
  parameter int RESP_DEPTH = 2,
  parameter int TIMEOUT    = 64,
  parameter int REG_OUT    = 0
) (
  input  logic           clk,
  input  logic           rst,
  core_wback_vl_if.slave bus
);
  localparam int CW  = $clog2(RESP_DEPTH) + 1;
  localparam int AW  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int WCW = (TIMEOUT == 0) ? 8 : ((TIMEOUT > 1) ? $clog2(TIMEOUT) : 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [AW-1:0]  PTR_LAST  = AW'(RESP_DEPTH - 1);

  logic [XLEN:0]   fifo_q [RESP_DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic [WCW-1:0]  wait_cnt;
  logic            overflow_q;

  logic            is_load, nonempty, full, resp_avail, timeout_hit;
  logic            retire, load_retire, pop, bypass, push, push_ok;
  logic [XLEN:0]   resp;
  logic            resp_err;
  logic [XLEN-1:0] resp_data, ext_data;
  logic [7:0]      sel_byte;
  logic [15:0]     sel_half;
  logic            wen_c, fault_c;
  logic [XLEN-1:0] wdata_c;

  assign is_load     = bus.w_valid && (bus.w_reg_wsel == 3'd2);
  assign nonempty    = (count != '0);
  assign full        = (count == CW'(RESP_DEPTH));
  assign resp_avail  = nonempty || bus.mem_rvalid;
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == WAIT_LAST) && !resp_avail;

  assign bus.w_ready = is_load ? (resp_avail || timeout_hit) : 1'b1;
  assign retire      = bus.w_valid && bus.w_ready;
  assign load_retire = is_load && resp_avail;
  assign pop         = load_retire && nonempty;
  assign bypass      = load_retire && !nonempty;
  assign push        = bus.mem_rvalid && !bypass;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok     = push && (!full || pop);

  assign resp      = nonempty ? fifo_q[rd_ptr] : {bus.mem_rerr, bus.mem_rdata};
  assign resp_err  = resp[XLEN];
  assign resp_data = resp[XLEN-1:0];

  always_comb begin
    sel_byte = resp_data[7:0];
    case (bus.w_alu_sum_lo)
      2'd1:    sel_byte = resp_data[15:8];
      2'd2:    sel_byte = resp_data[23:16];
      2'd3:    sel_byte = resp_data[31:24];
      default: sel_byte = resp_data[7:0];
    endcase
    sel_half = bus.w_alu_sum_lo[1] ? resp_data[31:16] : resp_data[15:0];
    case (bus.w_mem_type)
      3'b000:  ext_data = {{(XLEN-8){sel_byte[7]}}, sel_byte};
      3'b001:  ext_data = {{(XLEN-16){sel_half[15]}}, sel_half};
      3'b010:  ext_data = resp_data;
      3'b100:  ext_data = {{(XLEN-8){1'b0}}, sel_byte};
      3'b101:  ext_data = {{(XLEN-16){1'b0}}, sel_half};
      default: ext_data = '0;
    endcase
  end

  always_comb begin
    wdata_c = '0;
    case (bus.w_reg_wsel)
      3'd0:    wdata_c = bus.w_alu_out;
      3'd1:    wdata_c = bus.w_imm;
      3'd2:    wdata_c = ext_data;
      3'd3:    wdata_c = bus.w_pc;
      3'd4:    wdata_c = bus.w_pc4;
      3'd5:    wdata_c = bus.w_csr_value;
      default: wdata_c = '0;
    endcase
    wen_c   = bus.w_valid && bus.w_reg_wen;
    fault_c = 1'b0;
    if (is_load) begin
      wen_c   = load_retire && !resp_err && bus.w_reg_wen;
      fault_c = (load_retire && resp_err) || timeout_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_ptr] <= {bus.mem_rerr, bus.mem_rdata};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (pop)     rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      if (push_ok) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (pop && !push_ok) count <= count - 1'b1;
      if (push && !push_ok) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (!bus.w_valid || retire) begin
      wait_cnt <= '0;
    end else if (is_load && !resp_avail) begin
      if (TIMEOUT != 0 || wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign bus.mem_credit    = CW'(RESP_DEPTH) - count;
  assign bus.resp_overflow = overflow_q;

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic            wen_q, fault_q;
      logic [4:0]      waddr_q;
      logic [XLEN-1:0] wdata_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          wen_q   <= 1'b0;
          fault_q <= 1'b0;
          waddr_q <= '0;
          wdata_q <= '0;
        end else begin
          wen_q   <= wen_c;
          fault_q <= fault_c;
          waddr_q <= bus.w_rd;
          wdata_q <= wdata_c;
        end
      end
      assign bus.rf_wen     = wen_q;
      assign bus.load_fault = fault_q;
      assign bus.rf_waddr   = waddr_q;
      assign bus.rf_wdata   = wdata_q;
    end else begin : g_comb_out
      assign bus.rf_wen     = wen_c;
      assign bus.load_fault = fault_c;
      assign bus.rf_waddr   = bus.w_rd;
      assign bus.rf_wdata   = wdata_c;
    end
  endgenerate
endmodule

// File: tb/tb_core_wback_vl.sv
// Bench for core_wback_vl: directed scenarios plus random traffic against a queue-based model.
module tb_core_wback_vl;
  localparam int TO = 4;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;

  core_wback_vl_if #(.XLEN(32), .RESP_DEPTH(DEPTH)) bus ();

  core_wback_vl #(.XLEN(32), .RESP_DEPTH(DEPTH), .TIMEOUT(TO), .REG_OUT(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference state: pending responses {err,data}, cycles the current load has waited, sticky overflow.
  bit [32:0] mq[$];
  int        mw;
  bit        movf;
  bit        e_ready, ok_retire, to_hit;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mext(input logic [31:0] d, input logic [2:0] t, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(d >> (8 * off));
    h = 16'(d >> (16 * off[1]));
    case (t)
      3'b000:  return 32'($signed(b));
      3'b001:  return 32'($signed(h));
      3'b010:  return d;
      3'b100:  return 32'(b);
      3'b101:  return 32'(h);
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    mw   = 0;
    movf = 0;
  endtask

  task automatic sample();
    bit        ld, avail, e_wen, e_fault;
    bit [32:0] r;
    logic [31:0] e_data;
    @(negedge clk);
    ld      = bus.w_valid && bus.w_reg_wsel == 3'd2;
    avail   = (mq.size() > 0) || bus.mem_rvalid;
    to_hit  = ld && (mw == TO - 1) && !avail;
    e_ready = !ld || avail || to_hit;
    ok_retire = ld && avail;
    r = (mq.size() > 0) ? mq[0] : {bus.mem_rerr, bus.mem_rdata};
    case (bus.w_reg_wsel)
      3'd0: e_data = bus.w_alu_out;
      3'd1: e_data = bus.w_imm;
      3'd2: e_data = mext(r[31:0], bus.w_mem_type, bus.w_alu_sum_lo);
      3'd3: e_data = bus.w_pc;
      3'd4: e_data = bus.w_pc4;
      3'd5: e_data = bus.w_csr_value;
      default: e_data = 32'd0;
    endcase
    e_wen   = ld ? (ok_retire && !r[32] && bus.w_reg_wen) : (bus.w_valid && bus.w_reg_wen);
    e_fault = to_hit || (ok_retire && r[32]);
    check("w_ready", 32'(bus.w_ready), 32'(e_ready));
    check("mem_credit", 32'(bus.mem_credit), 32'(DEPTH - mq.size()));
    check("resp_overflow", 32'(bus.resp_overflow), 32'(movf));
    check("load_fault", 32'(bus.load_fault), 32'(e_fault));
    check("rf_wen", 32'(bus.rf_wen), 32'(e_wen));
    if (e_wen) begin
      check("rf_waddr", 32'(bus.rf_waddr), 32'(bus.w_rd));
      check("rf_wdata", bus.rf_wdata, e_data);
    end
  endtask

  task automatic advance();
    bit had;
    had = mq.size() > 0;
    if (ok_retire && had) void'(mq.pop_front());
    if (bus.mem_rvalid && !(ok_retire && !had)) begin
      if (mq.size() < DEPTH) mq.push_back({bus.mem_rerr, bus.mem_rdata});
      else movf = 1;
    end
    mw = (!bus.w_valid || e_ready) ? 0 : mw + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.w_valid = 0; bus.w_rd = 0; bus.w_reg_wen = 0; bus.w_reg_wsel = 0;
    bus.w_alu_out = 0; bus.w_imm = 0; bus.w_pc = 0; bus.w_pc4 = 0; bus.w_csr_value = 0;
    bus.w_alu_sum_lo = 0; bus.w_mem_type = 0;
    bus.mem_rvalid = 0; bus.mem_rdata = 0; bus.mem_rerr = 0;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [2:0] t, input logic [1:0] off);
    bus.w_valid = 1; bus.w_reg_wsel = 3'd2; bus.w_reg_wen = 1;
    bus.w_rd = rd; bus.w_mem_type = t; bus.w_alu_sum_lo = off;
  endtask

  task automatic lb_case(input logic [2:0] t, input logic [31:0] exp);
    set_load(5'd9, t, 2'd3);
    bus.mem_rvalid = 0;
    for (int i = 0; i < 3; i++) begin
      sample(); check("lb_stall", 32'(bus.w_ready), 32'd0); advance();
    end
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h80FF_0000;
    sample(); check("lb_ready", 32'(bus.w_ready), 32'd1); check("lb_data", bus.rf_wdata, exp);
    advance();
    bus.mem_rvalid = 0;
  endtask

  bit [2:0] types [7] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd7};

  initial begin
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_credit", 32'(bus.mem_credit), 32'd2);
    check("rst_overflow", 32'(bus.resp_overflow), 32'd0);
    check("rst_fault", 32'(bus.load_fault), 32'd0);
    rst = 0;

    // ALU result writes back in the cycle it is presented
    bus.w_valid = 1; bus.w_reg_wsel = 3'd0; bus.w_rd = 5'd5; bus.w_alu_out = 32'h1234; bus.w_reg_wen = 1;
    sample();
    check("alu_wen", 32'(bus.rf_wen), 32'd1);
    check("alu_waddr", 32'(bus.rf_waddr), 32'd5);
    check("alu_wdata", bus.rf_wdata, 32'h1234);
    check("alu_ready", 32'(bus.w_ready), 32'd1);
    advance();

    lb_case(3'b000, 32'hFFFF_FF80);
    lb_case(3'b100, 32'h0000_0080);

    // Two buffered responses then back-to-back LW loads
    idle_inputs();
    bus.mem_rvalid = 1; bus.mem_rdata = 32'hA;
    sample(); check("credit2", 32'(bus.mem_credit), 32'd2); advance();
    bus.mem_rdata = 32'hB;
    sample(); check("credit1", 32'(bus.mem_credit), 32'd1); advance();
    bus.mem_rvalid = 0;
    set_load(5'd3, 3'b010, 2'd0);
    sample(); check("credit0", 32'(bus.mem_credit), 32'd0); check("lw_a", bus.rf_wdata, 32'hA);
    check("lw_a_rdy", 32'(bus.w_ready), 32'd1); advance();
    sample(); check("lw_b", bus.rf_wdata, 32'hB); check("lw_b_rdy", 32'(bus.w_ready), 32'd1); advance();

    // Bus error on a buffered response
    idle_inputs();
    bus.mem_rvalid = 1; bus.mem_rerr = 1; bus.mem_rdata = 32'hDEAD_BEEF;
    sample(); advance();
    idle_inputs();
    set_load(5'd7, 3'b010, 2'd0);
    sample(); check("err_wen", 32'(bus.rf_wen), 32'd0); check("err_fault", 32'(bus.load_fault), 32'd1); advance();
    idle_inputs();
    sample(); check("err_fault_off", 32'(bus.load_fault), 32'd0); check("err_popped", 32'(bus.mem_credit), 32'd2); advance();

    // Timeout with no response
    set_load(5'd8, 3'b010, 2'd0);
    for (int i = 0; i < 3; i++) begin
      sample(); check("to_stall", 32'(bus.w_ready), 32'd0); advance();
    end
    sample(); check("to_ready", 32'(bus.w_ready), 32'd1); check("to_fault", 32'(bus.load_fault), 32'd1);
    check("to_wen", 32'(bus.rf_wen), 32'd0); advance();

    // Overflow with nothing consuming, then asynchronous reset mid-stream
    idle_inputs();
    bus.mem_rvalid = 1;
    for (int i = 0; i < 3; i++) begin
      bus.mem_rdata = 32'(i + 1); sample(); advance();
    end
    bus.mem_rvalid = 0;
    sample(); check("ovf_set", 32'(bus.resp_overflow), 32'd1); advance();
    sample(); check("ovf_sticky", 32'(bus.resp_overflow), 32'd1);
    bus.mem_rvalid = 1;
    #2 rst = 1;
    #1;
    check("rst_mid_ovf", 32'(bus.resp_overflow), 32'd0);
    check("rst_mid_credit", 32'(bus.mem_credit), 32'd2);
    @(posedge clk); #1;
    idle_inputs(); model_reset();
    rst = 0;

    // Random traffic; a stalled instruction is held until it retires
    for (int c = 0; c < 3000; c++) begin
      if (!(bus.w_valid && !e_ready) || c == 0) begin
        bus.w_valid = ($urandom_range(0, 3) != 0);
        bus.w_reg_wsel = ($urandom_range(0, 1) != 0) ? 3'd2 : 3'($urandom_range(0, 7));
        bus.w_rd = 5'($urandom); bus.w_reg_wen = ($urandom_range(0, 4) != 0);
        bus.w_alu_out = $urandom; bus.w_imm = $urandom; bus.w_pc = $urandom;
        bus.w_pc4 = $urandom; bus.w_csr_value = $urandom;
        bus.w_alu_sum_lo = 2'($urandom); bus.w_mem_type = types[$urandom_range(0, 6)];
      end
      bus.mem_rvalid = ($urandom_range(0, 9) < 4);
      bus.mem_rdata = $urandom;
      bus.mem_rerr = ($urandom_range(0, 9) == 0);
      sample();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/core_wback_vl.md
Name: core_wback_vl

Overview:
- Writeback stage for data memories with variable load latency. Successor to the fixed single-cycle writeback.
- Buffers in-order load responses in a small response FIFO and stalls the W stage (deasserts w_ready) while a load waits for data.
- Handles bus errors and load timeouts, and optionally registers the register-file write port.
- Sits between the M/W pipeline register and the register file.

Parameters:
- XLEN, 32, datapath width; must be 32.
- RESP_DEPTH, 2, response FIFO entries; power of two, ≥1.
- TIMEOUT, 64, max wait cycles for a load in W; 0 disables the timeout.
- REG_OUT, 0, 1 registers rf_wen/rf_waddr/rf_wdata (+1 cycle latency).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- w_valid  in  1  instruction present in W
- w_ready  out  1  W accepts/retires the instruction this cycle
- w_rd  in  5  destination register
- w_reg_wen  in  1  instruction writes rd
- w_reg_wsel  in  3  source select: 0 ALU, 1 IMM, 2 MEM, 3 PC, 4 PC4, 5 CSR
- w_alu_out / w_imm / w_pc / w_pc4 / w_csr_value  in  XLEN each  candidate results
- w_alu_sum_lo  in  2  load byte offset
- w_mem_type  in  3  RISC-V funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- mem_rvalid  in  1  load response valid (one-cycle pulse per response, in order)
- mem_rdata  in  XLEN  response data
- mem_rerr  in  1  response carries a bus error
- mem_credit  out  clog2(RESP_DEPTH)+1  free FIFO entries
- rf_wen  out  1  register-file write enable
- rf_waddr  out  5  write address
- rf_wdata  out  XLEN  write data
- load_fault  out  1  one-cycle pulse: load retired with error or timeout
- resp_overflow  out  1  sticky: response arrived while FIFO full

Behaviour:
- Reset values (async): FIFO empty, wait counter 0, resp_overflow 0, load_fault 0, registered rf_* 0. mem_credit = RESP_DEPTH.
- is_load = w_valid && w_reg_wsel==2.
- Non-load: w_ready=1 and it retires in the cycle presented. rf_wen = w_valid && w_reg_wen.
- Load: resp_avail = (count>0) || mem_rvalid.
  - Head of FIFO is used when count>0.
  - Otherwise the incoming response is bypassed in the same cycle with no push.
  - w_ready = resp_avail || timeout_hit.
- Load retire on response: pop (or bypass). Then:
  - If the error bit is clear: rf_wen = w_reg_wen, rf_wdata = extended data.
  - If the error bit is set: rf_wen=0 and load_fault=1.
- Extension:
  - LB/LBU select byte offset[1:0].
  - LH/LHU select halfword offset[1] (offset[0] ignored).
  - LW ignores offset.
  - Signed types sign-extend; unsigned types zero-extend.
  - Unlisted mem_type: zero data, write still performed.
- Non-MEM wsel codes 6,7: rf_wdata = 0.
- FIFO push: mem_rvalid && !(bypass consumption).
  - Simultaneous push and pop keeps count unchanged.
  - Push when full without pop: response dropped, resp_overflow set until reset.
- mem_credit = RESP_DEPTH − count (combinational from registered count).
- Wait counter:
  - Increments each cycle a load is in W with resp_avail=0.
  - Clears on any retire or when !w_valid.
  - timeout_hit = TIMEOUT≠0 && counter==TIMEOUT−1 && !resp_avail.
  - On timeout_hit the load retires with rf_wen=0 and load_fault=1. Its late response is later pushed normally; flushing it is the upstream's responsibility.
- Counter saturates (never wraps) when TIMEOUT=0.
- REG_OUT=1: rf_*, load_fault registered one cycle later; w_ready timing unchanged.
- Reset mid-wait: FIFO and counter cleared immediately; no rf write.

Test Plan:
- ALU op w_rd=5, w_alu_out=0x1234, wen=1 -> same cycle rf_wen=1, waddr=5, wdata=0x1234, w_ready=1.
- LB offset 3, response 0x80FF_0000 arriving 3 cycles after load enters W -> w_ready=0 for 3 cycles, then rf_wdata=0xFFFF_FF80. Same load as LBU -> 0x0000_0080.
- Two responses (0xA, 0xB) arrive before two back-to-back LW loads enter W; RESP_DEPTH=2 -> mem_credit 2→1→0, loads retire consecutively with 0xA then 0xB, no stall.
- Response with mem_rerr=1 for LW rd=7 -> rf_wen=0, load_fault pulses 1 cycle, FIFO entry popped.
- TIMEOUT=4, load with no response -> w_ready=0 for 3 cycles, retires in 4th with load_fault=1, rf_wen=0.
- Three responses with no load in W, RESP_DEPTH=2 -> resp_overflow=1 and stays set. Assert rst mid-stream -> overflow=0, mem_credit=2 immediately.
